// File: rtl/bin_to_bcd_seq_pkg.sv
// rtl/bin_to_bcd_seq_pkg.sv - shared FSM encoding and BCD constants for bin_to_bcd_seq
package bin_to_bcd_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int         NUM_DIGITS      = 4;
  localparam int         SCRATCH_W       = 4 * NUM_DIGITS;
  localparam logic [3:0] BCD_BLANK       = 4'hF;
  localparam logic [3:0] BCD_ADD3_THRESH = 4'd5;

endpackage

// File: rtl/bcd_add3.sv
// rtl/bcd_add3.sv - double-dabble nibble correction: adds 3 when the nibble is 5 or more
module bcd_add3
  import bin_to_bcd_seq_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [3:0] corrected
);

  // Legal BCD nibbles top out at 9, so the sum never exceeds 12 and fits in 4 bits.
  assign corrected = (nibble >= BCD_ADD3_THRESH) ? nibble + 4'd3 : nibble;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// rtl/bin_to_bcd_seq.sv - sequential double-dabble binary to 4-digit BCD converter
// Optional leading-zero blanking of dig3..dig1 with BCD_LEADING_BLANK_EN.
module bin_to_bcd_seq
  import bin_to_bcd_seq_pkg::*;
#(
  parameter int W = 12
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] bin,
  output logic         busy,
  output logic         done,
  output logic [3:0]   dig3,
  output logic [3:0]   dig2,
  output logic [3:0]   dig1,
  output logic [3:0]   dig0
);

  localparam int CNT_W = $clog2(W + 1);

  state_t               state;
  logic [W-1:0]         shreg;
  logic [SCRATCH_W-1:0] scratch;
  logic [SCRATCH_W-1:0] corrected;
  logic [SCRATCH_W-1:0] next_scratch;
  logic [SCRATCH_W-1:0] result;
  logic [CNT_W-1:0]     count;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .nibble    (scratch[4*g +: 4]),
      .corrected (corrected[4*g +: 4])
    );
  end

  assign next_scratch = {corrected[SCRATCH_W-2:0], shreg[W-1]};

`ifdef BCD_LEADING_BLANK_EN
  // dig0 is excluded from blanking so a zero reading still shows one digit.
  always_comb begin
    logic lead;
    result = next_scratch;
    lead   = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      if (lead && (next_scratch[4*i +: 4] == 4'd0)) begin
        result[4*i +: 4] = BCD_BLANK;
      end else begin
        lead = 1'b0;
      end
    end
  end
`else
  assign result = next_scratch;
`endif

  // Digits load on the final shift edge so they and done appear together in DONE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      shreg   <= '0;
      scratch <= '0;
      count   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      dig3    <= 4'h0;
      dig2    <= 4'h0;
      dig1    <= 4'h0;
      dig0    <= 4'h0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            shreg   <= bin;
            scratch <= '0;
            count   <= CNT_W'(W);
            busy    <= 1'b1;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          scratch <= next_scratch;
          shreg   <= {shreg[W-2:0], 1'b0};
          count   <= count - CNT_W'(1);
          if (count == CNT_W'(1)) begin
            dig3  <= result[15:12];
            dig2  <= result[11:8];
            dig1  <= result[7:4];
            dig0  <= result[3:0];
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// tb/tb_bin_to_bcd_seq.sv - directed self-checking bench for bin_to_bcd_seq
module tb_bin_to_bcd_seq;

  localparam int W = 12;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] bin;
  logic         busy;
  logic         done;
  logic [3:0]   dig3, dig2, dig1, dig0;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] last   = 16'h0000;

  always #5 clk = ~clk;

  bin_to_bcd_seq #(.W(W)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .dig3  (dig3),
    .dig2  (dig2),
    .dig1  (dig1),
    .dig0  (dig0)
  );

  function automatic logic [15:0] digs();
    return {dig3, dig2, dig1, dig0};
  endfunction

  // Decimal reference, independent of the shift-add-3 method.
  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [15:0] shown(input logic [15:0] d);
    logic [15:0] r;
    r = d;
`ifdef BCD_LEADING_BLANK_EN
    if (r[15:12] == 4'h0) begin
      r[15:12] = 4'hF;
      if (r[11:8] == 4'h0) begin
        r[11:8] = 4'hF;
        if (r[7:4] == 4'h0) r[7:4] = 4'hF;
      end
    end
`endif
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One conversion from IDLE: latency, busy, hold of old digits, result, single-cycle done.
  task automatic run(input string tag, input logic [W-1:0] v, input logic [15:0] exp);
    int n;
    bit seen, busy_ok, hold_ok;
    start = 1'b1;
    bin   = v;
    tick();
    start = 1'b0;
    bin   = W'($urandom);
    n = 1; seen = 0; busy_ok = 1; hold_ok = 1;
    while (!seen && n <= 40) begin
      if (!busy) busy_ok = 0;
      if (done) seen = 1;
      else begin
        if (digs() !== last) hold_ok = 0;
        tick();
        n++;
      end
    end
    check({tag, "_latency"}, 32'(n), 32'd13);
    check({tag, "_busy"}, 32'(busy_ok), 32'd1);
    check({tag, "_hold"}, 32'(hold_ok), 32'd1);
    check({tag, "_digits"}, 32'(digs()), 32'(exp));
    tick();
    check({tag, "_done_pulse"}, {30'd0, busy, done}, 32'd0);
    last = exp;
  endtask

  initial begin
    int last_done, ndone;
    logic [W-1:0] pending;
    bit stray;

    reset = 1'b1;
    start = 1'b0;
    bin   = '0;
    tick();
    tick();
    check("reset_state", {13'd0, busy, done, digs()}, 32'd0);
    reset = 1'b0;
    tick();

    run("zero", 12'd0, shown(16'h0000));
    run("max", 12'd4095, shown(16'h4095));
    run("second", 12'd1234, shown(16'h1234));

    // start held high: only IDLE accepts, and results track the accepted bin.
    start = 1'b1;
    last_done = -1;
    ndone = 0;
    pending = '0;
    for (int i = 0; i < 45; i++) begin
      logic [W-1:0] v;
      v = W'(i * 97 + 5);
      if (!busy) pending = v;
      bin = v;
      tick();
      if (done) begin
        check("held_digits", 32'(digs()), 32'(shown(to_bcd(int'(pending)))));
        if (last_done >= 0) check("held_spacing", 32'(i - last_done), 32'd14);
        last_done = i;
        ndone++;
      end
    end
    start = 1'b0;
    check("held_count", 32'(ndone), 32'd3);
    for (int i = 0; i < 20 && busy; i++) tick();
    check("held_idle", 32'(busy), 32'd0);
    last = shown(to_bcd(int'(pending)));

    run("r999", 12'd999, shown(16'h0999));

    // Asynchronous abort in cycle 6 of a conversion.
    start = 1'b1;
    bin   = 12'd2048;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    #2 reset = 1'b1;
    #1 check("abort_async", {13'd0, busy, done, digs()}, 32'd0);
    tick();
    reset = 1'b0;
    last  = 16'h0000;
    stray = 0;
    for (int i = 0; i < 20; i++) begin
      if (done || busy) stray = 1;
      tick();
    end
    check("abort_no_done", 32'(stray), 32'd0);
    run("r2048", 12'd2048, shown(16'h2048));

    run("b9", 12'd9, shown(16'h0009));
    run("b10", 12'd10, shown(16'h0010));
    run("b99", 12'd99, shown(16'h0099));
    run("b100", 12'd100, shown(16'h0100));
    run("b1000", 12'd1000, shown(16'h1000));

`ifdef BCD_LEADING_BLANK_EN
    run("blank7", 12'd7, 16'hFFF7);
    run("blank0", 12'd0, 16'hFFF0);
    run("blank305", 12'd305, 16'hF305);
    run("blank1005", 12'd1005, 16'h1005);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
